// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus blocks.
//   - Arbiter state encoding (IDLE / BUSY / DONE)
//   - Default address and data widths used by the core datapath
//   - idx_width(): bit width needed to index n items. It never returns
//     less than one bit, so that degenerate sizes still get a real vector.
package mem_bus_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority pick.
// Scans the request vector starting at i_rr_ptr and wrapping modulo
// NUM_PORTS. It returns the first set bit as a one-hot grant and as an
// encoded index.
//
// Ports:
//   i_req        request vector, one bit per channel
//   i_rr_ptr     channel with the highest priority for this pick
//   o_grant      one-hot grant; all zeros when no channel requests
//   o_grant_idx  encoded index of the granted channel
//   o_any        high when at least one channel requests
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_grant_idx,
    output logic                 o_any
);

    logic [31:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            // The pointer is always below NUM_PORTS, so a single subtraction
            // is enough to wrap the candidate back into range.
            w_cand = 32'(i_rr_ptr) + i;
            if (w_cand >= NUM_PORTS) begin
                w_cand = w_cand - NUM_PORTS;
            end
            if (!o_any && i_req[w_cand[IDX_W-1:0]]) begin
                o_any                        = 1'b1;
                o_grant[w_cand[IDX_W-1:0]]   = 1'b1;
                o_grant_idx                  = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges NUM_PORTS requesters onto one external memory bus. The bus uses
// the addr / rden / wren / read_val / write_val / response handshake.
// Requesters are served in round-robin order, with at most one
// transaction on the bus at a time. An optional response timeout ends a
// transaction with an error. TIMEOUT = 0 disables the timeout.
//
// Ports:
//   clk, reset          rising-edge clock; synchronous active-high reset
//   req_valid/wr        per-channel request pending / 1 = write
//   req_addr/wdata      packed per-channel address and write data
//                       (channel i at [i*W +: W])
//   req_ready           one-hot accept pulse, combinational in IDLE
//   resp_valid/err      one-hot completion pulse / timeout flag
//   resp_rdata          read data; valid together with resp_valid
//   memory_*            external bus; strobes are high only while BUSY
//   memory_response     single-cycle completion from memory
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DATA_W    = MEM_DATA_W,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [NUM_PORTS-1:0]        resp_valid,
    output logic [NUM_PORTS-1:0]        resp_err,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic [ADDR_W-1:0]           memory_addr,
    output logic                        memory_rden,
    output logic                        memory_wren,
    output logic [DATA_W-1:0]           memory_write_val,
    input  logic [DATA_W-1:0]           memory_read_val,
    input  logic                        memory_response
);

    localparam int unsigned IDX_W = idx_width(NUM_PORTS);
    localparam int unsigned CNT_W = idx_width(TIMEOUT + 1);

    mem_state_e             r_state;
    mem_state_e             w_state_nxt;

    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_gidx;
    logic [NUM_PORTS-1:0]   r_goh;
    logic                   r_wr;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cnt;

    logic [NUM_PORTS-1:0]   w_grant;
    logic [IDX_W-1:0]       w_gidx;
    logic                   w_any;
    logic                   w_accept;
    logic                   w_timeout;
    logic [IDX_W-1:0]       w_ptr_nxt;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .i_req       (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any       (w_any)
    );

    // The counter holds the number of BUSY cycles already completed. A
    // match against TIMEOUT-1 therefore ends the transaction after exactly
    // TIMEOUT strobe cycles.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    assign w_ptr_nxt = (r_gidx == IDX_W'(NUM_PORTS - 1)) ? '0 : r_gidx + IDX_W'(1);

    assign resp_rdata = r_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_accept         = 1'b0;
        req_ready        = '0;
        resp_valid       = '0;
        resp_err         = '0;
        memory_rden      = 1'b0;
        memory_wren      = 1'b0;
        memory_addr      = '0;
        memory_write_val = '0;
        unique case (r_state)
            IDLE: begin
                // While reset is asserted, no grant is shown, so that every
                // output stays zero.
                if (w_any && !reset) begin
                    req_ready   = w_grant;
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                memory_addr      = r_addr;
                memory_write_val = r_wdata;
                memory_rden      = ~r_wr;
                memory_wren      = r_wr;
                if (memory_response || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                resp_valid  = r_goh;
                resp_err    = r_err ? r_goh : '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_gidx   <= '0;
            r_goh    <= '0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_gidx  <= w_gidx;
                r_goh   <= w_grant;
                r_wr    <= req_wr[w_gidx];
                r_addr  <= req_addr[w_gidx*ADDR_W +: ADDR_W];
                r_wdata <= req_wdata[w_gidx*DATA_W +: DATA_W];
                r_err   <= 1'b0;
                r_cnt   <= '0;
            end
            if (r_state == BUSY) begin
                // A response in the same cycle as the timeout wins.
                if (memory_response) begin
                    r_rdata <= r_wr ? '0 : memory_read_val;
                    r_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else if (r_cnt < CNT_W'(TIMEOUT)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (r_state == DONE) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised, multi-channel successor to the core's single memory port.
- Merges NUM_PORTS independent requesters (e.g. instruction fetch, data load/store, debug) onto the one external memory bus.
- The memory bus uses the existing addr/rden/wren/read_val/write_val/response handshake.
- Fair round-robin arbitration, one outstanding transaction at a time, optional response timeout with error reporting.

Parameters:
- NUM_PORTS, 2, number of requester channels (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, cycles to wait for memory_response before abort; 0 disables timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-channel request pending.
- req_wr  in  NUM_PORTS  per-channel: 1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  packed write data.
- req_ready  out  NUM_PORTS  one-hot accept pulse.
- resp_valid  out  NUM_PORTS  one-hot completion pulse.
- resp_err  out  NUM_PORTS  one-hot timeout pulse, coincident with resp_valid.
- resp_rdata  out  DATA_W  read data, valid with resp_valid.
- memory_addr  out  ADDR_W  bus address.
- memory_rden  out  1  read strobe.
- memory_wren  out  1  write strobe.
- memory_write_val  out  DATA_W  write data.
- memory_read_val  in  DATA_W  read data, sampled when memory_response=1.
- memory_response  in  1  single-cycle completion from memory.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0; timeout counter 0.
- Reset asserted mid-transaction: transaction dropped; strobes low from the next edge; no resp pulse.

FSM states: IDLE, BUSY, DONE.

IDLE:
- If any req_valid is set, grant the first set bit scanning rr_ptr, rr_ptr+1, … mod NUM_PORTS.
- req_ready[g]=1 combinationally in this cycle.
- Latch g, req_wr, addr and wdata; go to BUSY.
- Requester must hold its inputs stable until it sees req_ready.

BUSY:
- Drive memory_addr and memory_write_val from the latched values.
- Drive memory_rden=~wr and memory_wren=wr. Never both high.
- Strobes stay high every cycle until memory_response=1.
- Response received: register memory_read_val into resp_rdata (writes give 0); go to DONE.
- TIMEOUT≠0 and counter reaches TIMEOUT with no response: set resp_err, resp_rdata=0, go to DONE.
- Counter clears on entry to BUSY.

DONE (one cycle):
- resp_valid[g]=1, plus resp_err[g] if the transaction timed out.
- Strobes low.
- rr_ptr=(g+1) mod NUM_PORTS, wrapping at NUM_PORTS-1 → 0.
- Go to IDLE.

Latency and throughput:
- Accept at cycle 0, first strobe at cycle 1.
- Response at cycle k (k≥1) gives resp_valid at cycle k+1.
- Minimum request-to-request spacing on the bus: 3 cycles.

Boundary conditions:
- memory_response while in IDLE or DONE: ignored.
- A late response arriving after a timeout: ignored.
- Simultaneous requests: exactly one grant per cycle; all others wait, req_ready=0.
- NUM_PORTS=1: rr_ptr is constant 0.
- Timeout counter width is clog2(TIMEOUT+1); it saturates and does not wrap.

Decomposition:
- Shared package mem_bus_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and default ADDR_W/DATA_W constants, reused by the core datapath.
- One sub-module, rr_arbiter: combinational round-robin priority pick.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant, encoded index.
- FSM, latches and timeout counter stay in the top module.

Test Plan:
- Single read: ch0 read addr 0x100, memory responds at cycle 3 with 0xDEADBEEF → req_ready[0] at cycle 0, memory_rden high cycles 1–3, resp_valid[0] with resp_rdata=0xDEADBEEF at cycle 4.
- Write: ch1 write addr 0x20, data 0x12345678, response after 1 cycle → memory_wren=1, memory_rden=0, memory_write_val=0x12345678; resp_valid[1] with resp_rdata=0.
- Contention: ch0 and ch1 both held valid for 4 transactions, response delay 1 → grant order 0,1,0,1; rr_ptr toggles.
- Timeout: TIMEOUT=4, ch0 read, no response → strobes high for exactly 4 cycles, then resp_valid[0]=resp_err[0]=1, resp_rdata=0; a response pulse 2 cycles later is ignored.
- Reset mid-op: reset for one cycle during BUSY → next cycle all outputs 0, no resp pulse; a subsequent ch1 request completes normally.
- Stray response: memory_response pulsed while IDLE with no requests → no resp_valid, state stays IDLE.
